// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a fill/store FSM.
// Define DCACHE_STATS_EN to add the hit_count/miss_count load counters.
module data_cache #(
  parameter int WIDTH      = 32,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [1:0]       cpu_size,
  input  logic             cpu_sign,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_size,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);
  localparam int WB   = $clog2(LINE_WORDS);
  localparam int IB   = $clog2(SETS);
  localparam int TAGW = WIDTH - 2 - WB - IB;
  localparam logic [WB-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, FILL, STORE} state_t;
  state_t state;

  logic [SETS-1:0]                        valid;
  logic [TAGW-1:0]                        tag_arr  [SETS];
  logic [LINE_WORDS-1:0][WIDTH-1:0]       data_arr [SETS];
  logic [WB-1:0]                          cnt;

  logic [WB-1:0]   wsel;
  logic [IB-1:0]   idx;
  logic [TAGW-1:0] tag;
  logic            hit, fill_wr, fill_last, store_hit;
  logic [WIDTH-1:0] rword, wsrc, wmerge, ext;
  logic [3:0]      be;
  logic [15:0]     hsel;
  logic [7:0]      bsel;

  assign wsel  = cpu_addr[2 +: WB];
  assign idx   = cpu_addr[2+WB +: IB];
  assign tag   = cpu_addr[WIDTH-1 -: TAGW];
  assign hit   = valid[idx] && (tag_arr[idx] == tag);
  assign rword = data_arr[idx][wsel];

  assign fill_wr   = (state == FILL) && mem_ready;
  assign fill_last = fill_wr && (cnt == LAST);
  assign store_hit = (state == IDLE) && cpu_req && cpu_we && hit;

  // Byte lanes assume 32-bit words; store data is replicated so every lane sees its bytes.
  always_comb begin
    case (cpu_size)
      2'b01:   begin be = cpu_addr[1] ? 4'b1100 : 4'b0011; wsrc = {2{cpu_wdata[15:0]}}; end
      2'b10:   begin be = 4'b0001 << cpu_addr[1:0];        wsrc = {4{cpu_wdata[7:0]}};  end
      default: begin be = 4'b1111;                         wsrc = cpu_wdata;            end
    endcase
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign wmerge[8*b +: 8] = be[b] ? wsrc[8*b +: 8] : rword[8*b +: 8];
  end

  always_comb begin
    hsel = cpu_addr[1] ? rword[31:16] : rword[15:0];
    bsel = rword[{cpu_addr[1:0], 3'b000} +: 8];
    case (cpu_size)
      2'b01:   ext = cpu_sign ? {{16{hsel[15]}}, hsel} : {16'b0, hsel};
      2'b10:   ext = cpu_sign ? {{24{bsel[7]}}, bsel}  : {24'b0, bsel};
      default: ext = rword;
    endcase
  end

  assign cpu_rdata = (state == IDLE && cpu_req && !cpu_we && hit) ? ext : '0;

  always_comb begin
    case (state)
      IDLE:    cpu_stall = cpu_req && (cpu_we || !hit);
      FILL:    cpu_stall = 1'b1;
      STORE:   cpu_stall = !mem_ready;
      default: cpu_stall = 1'b0;
    endcase
  end

  assign mem_size  = (state == FILL) ? 2'b00 : cpu_size;
  assign mem_addr  = (state == FILL) ? {tag, idx, cnt, 2'b00} : cpu_addr;
  assign mem_wdata = cpu_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      valid   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          if (cpu_we) begin
            state   <= STORE;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end else if (!hit) begin
            // Invalidate up front so an interrupted fill never leaves a mixed line valid.
            state      <= FILL;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            cnt        <= '0;
            valid[idx] <= 1'b0;
          end
        end
        FILL: if (mem_ready) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            valid[idx] <= 1'b1;
            state      <= IDLE;
            mem_req    <= 1'b0;
          end
        end
        STORE: if (mem_ready) begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_wr)   data_arr[idx][cnt]  <= mem_rdata;
      if (fill_last) tag_arr[idx]        <= tag;
      if (store_hit) data_arr[idx][wsel] <= wmerge;
    end
  end

`ifdef DCACHE_STATS_EN
  // The cycle right after a fill is the replayed load; it must not count again.
  logic replay;
  always_ff @(posedge clk) begin
    if (rst) begin
      replay     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      replay <= fill_last;
      if (state == IDLE && cpu_req && !cpu_we && !replay) begin
        if (hit) begin
          if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 1'b1;
        end else begin
          if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 1'b1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a word-addressed backing memory answers every request
// in the cycle it is issued; reads and writes are logged for checking.
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_sign;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_ready;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign mem_ready = mem_req;
  assign mem_rdata = mem[mem_addr[11:2]];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] rd_log[$];
  int          wr_cnt = 0;
  logic [31:0] wr_addr, wr_data;
  logic [1:0]  wr_size;

  always @(posedge clk) begin
    if (mem_req && mem_ready && !rst) begin
      if (mem_we) begin
        wr_cnt++;
        wr_addr = mem_addr; wr_data = mem_wdata; wr_size = mem_size;
        case (mem_size)
          2'b01:   mem[mem_addr[11:2]][{mem_addr[1], 4'b0000} +: 16] = mem_wdata[15:0];
          2'b10:   mem[mem_addr[11:2]][{mem_addr[1:0], 3'b000} +: 8] = mem_wdata[7:0];
          default: mem[mem_addr[11:2]] = mem_wdata;
        endcase
      end else begin
        rd_log.push_back(mem_addr);
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn,
                         output logic [31:0] data, output int stalls);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = sz; cpu_sign = sgn; cpu_addr = a;
    stalls = 0; data = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin data = cpu_rdata; break; end
      stalls++;
    end
    checks++;
    if (stalls >= 50) begin errors++; $display("FAIL load_timeout: addr %h still stalled after %0d cycles, required release", a, stalls); end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                          output int stalls);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = sz; cpu_sign = 1'b0; cpu_addr = a; cpu_wdata = d;
    stalls = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
    end
    checks++;
    if (stalls >= 50) begin errors++; $display("FAIL store_timeout: addr %h still stalled after %0d cycles, required release", a, stalls); end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
    checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we: got %b required 0", mem_we); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", cpu_rdata); end
  endtask

  task automatic test_fill();
    logic [31:0] d; int st;
    rd_log.delete();
    do_load(32'h40, 2'b00, 1'b0, d, st);
    checks++; if (rd_log.size() != 4) begin errors++; $display("FAIL fill_reads: got %0d required 4", rd_log.size()); end
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      checks++;
      if (rd_log[i] !== 32'h40 + 32'(4*i)) begin errors++; $display("FAIL fill_addr%0d: got %h required %h", i, rd_log[i], 32'h40 + 32'(4*i)); end
    end
    checks++; if (st != 5) begin errors++; $display("FAIL fill_stalls: got %0d required 5", st); end
    checks++; if (d !== 32'h1000_0040) begin errors++; $display("FAIL fill_replay: got %h required 10000040", d); end
    rd_log.delete();
    do_load(32'h4C, 2'b00, 1'b0, d, st);
    checks++; if (st != 0 || rd_log.size() != 0) begin errors++; $display("FAIL line_valid: got stalls %0d reads %0d required 0 0", st, rd_log.size()); end
    checks++; if (d !== 32'h1000_004C) begin errors++; $display("FAIL line_word3: got %h required 1000004c", d); end
  endtask

  task automatic test_load_ext();
    logic [31:0] d; int st;
    do_load(32'h80, 2'b10, 1'b1, d, st);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL lb_80: got %h required fffffffe", d); end
    checks++; if (st != 5) begin errors++; $display("FAIL lb_80_stalls: got %0d required 5", st); end
    do_load(32'h81, 2'b10, 1'b0, d, st);
    checks++; if (d !== 32'h0000_00F0 || st != 0) begin errors++; $display("FAIL lbu_81: got %h/%0d required 000000f0/0", d, st); end
    do_load(32'h82, 2'b01, 1'b1, d, st);
    checks++; if (d !== 32'hFFFF_8001 || st != 0) begin errors++; $display("FAIL lh_82: got %h/%0d required ffff8001/0", d, st); end
    do_load(32'h80, 2'b01, 1'b0, d, st);
    checks++; if (d !== 32'h0000_F0FE) begin errors++; $display("FAIL lhu_80: got %h required 0000f0fe", d); end
    do_load(32'h83, 2'b11, 1'b1, d, st);
    checks++; if (d !== 32'h8001_F0FE) begin errors++; $display("FAIL size11_83: got %h required 8001f0fe", d); end
  endtask

  task automatic test_store_hit();
    logic [31:0] d; int st; int w0;
    w0 = wr_cnt; rd_log.delete();
    do_store(32'h41, 2'b10, 32'h0000_0012, st);
    checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL sb_writes: got %0d required 1", wr_cnt - w0); end
    checks++; if (wr_size !== 2'b10 || wr_addr !== 32'h41 || wr_data[7:0] !== 8'h12) begin
      errors++; $display("FAIL sb_mem: got size %b addr %h data %h required 10 41 12", wr_size, wr_addr, wr_data); end
    checks++; if (st != 1) begin errors++; $display("FAIL sb_stalls: got %0d required 1", st); end
    do_load(32'h40, 2'b00, 1'b0, d, st);
    checks++; if (d !== 32'h1000_1240 || st != 0 || rd_log.size() != 0) begin
      errors++; $display("FAIL sb_merge: got %h/%0d/%0d required 10001240/0/0", d, st, rd_log.size()); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b00; cpu_sign = 1'b0; cpu_addr = 32'h44;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h1000_0044) begin errors++; $display("FAIL b2b_0: got %b/%h required 0/10000044", cpu_stall, cpu_rdata); end
    @(posedge clk); #1;
    cpu_size = 2'b01; cpu_addr = 32'h4E;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0000_1000) begin errors++; $display("FAIL b2b_1: got %b/%h required 0/00001000", cpu_stall, cpu_rdata); end
    @(posedge clk); #1;
    cpu_size = 2'b10; cpu_sign = 1'b1; cpu_addr = 32'h41;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0000_0012) begin errors++; $display("FAIL b2b_2: got %b/%h required 0/00000012", cpu_stall, cpu_rdata); end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_store_miss();
    logic [31:0] d; int st; int w0;
    w0 = wr_cnt; rd_log.delete();
    do_store(32'h200, 2'b00, 32'hDEAD_BEEF, st);
    checks++; if (wr_cnt - w0 != 1 || rd_log.size() != 0) begin errors++; $display("FAIL sw_miss: got writes %0d reads %0d required 1 0", wr_cnt - w0, rd_log.size()); end
    do_load(32'h200, 2'b00, 1'b0, d, st);
    checks++; if (st != 5 || rd_log.size() != 4) begin errors++; $display("FAIL sw_no_alloc: got stalls %0d reads %0d required 5 4", st, rd_log.size()); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_200: got %h required deadbeef", d); end
    do_load(32'h80, 2'b10, 1'b1, d, st);
    checks++; if (st != 5 || d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL evict_80: got %0d/%h required 5/fffffffe", st, d); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d; int st;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b00; cpu_sign = 1'b0; cpu_addr = 32'h300;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_fill: got req %b stall %b required 0 0", mem_req, cpu_stall); end
    rd_log.delete();
    do_load(32'h300, 2'b00, 1'b0, d, st);
    checks++; if (rd_log.size() != 4 || st != 5) begin errors++; $display("FAIL refetch: got reads %0d stalls %0d required 4 5", rd_log.size(), st); end
    checks++; if (rd_log.size() > 0 && rd_log[0] !== 32'h300) begin errors++; $display("FAIL refetch_addr: got %h required 00000300", rd_log[0]); end
    checks++; if (d !== 32'h1000_0300) begin errors++; $display("FAIL refetch_data: got %h required 10000300", d); end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    logic [31:0] d; int st;
    do_reset();
    @(negedge clk);
    checks++; if (hit_count !== 0 || miss_count !== 0) begin errors++; $display("FAIL stats_reset: got %0d/%0d required 0/0", hit_count, miss_count); end
    do_load(32'h500, 2'b00, 1'b0, d, st);
    do_load(32'h504, 2'b00, 1'b0, d, st);
    do_store(32'h504, 2'b00, 32'h1, st);
    do_load(32'h508, 2'b00, 1'b0, d, st);
    @(negedge clk);
    checks++; if (hit_count !== 2 || miss_count !== 1) begin errors++; $display("FAIL stats_count: got %0d/%0d required 2/1", hit_count, miss_count); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(4*i);
    mem[32'h80 >> 2] = 32'h8001_F0FE;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_sign = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_fill();
    test_load_ext();
    test_store_hit();
    test_back_to_back();
    test_store_miss();
    test_reset_mid_fill();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
